// File: rtl/cache_port_arbiter.sv
// Two-master round-robin arbiter for the cache's single CPU-side port.
// Optional response watchdog enabled by defining CACHE_ARB_WATCHDOG_EN.
module cache_port_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_resp,
    output logic              m0_err,
    input  logic [2:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_resp,
    output logic              m1_err,
    output logic [2:0]        c_cmd,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    input  logic [DATA_W-1:0] c_rdata,
    input  logic              c_resp
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] CMD_READ32 = 3'd3;

    state_t      state_q;
    logic        last_q;   // master granted most recently
    logic        owner_q;  // master owning the current transaction
    logic [1:0]  beats_q;  // response beats still outstanding

    logic              req0, req1, gnt1;
    logic [2:0]        win_cmd;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // On contention the master opposite the last grant wins.
    always_comb begin
        req0      = |m0_cmd;
        req1      = |m1_cmd;
        gnt1      = req1 && (!req0 || !last_q);
        win_cmd   = gnt1 ? m1_cmd   : m0_cmd;
        win_addr  = gnt1 ? m1_addr  : m0_addr;
        win_wdata = gnt1 ? m1_wdata : m0_wdata;
    end

`ifdef CACHE_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
`else
    localparam int unused_timeout = TIMEOUT;
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            beats_q  <= '0;
            c_cmd    <= '0;
            c_addr   <= '0;
            c_wdata  <= '0;
            m0_rdata <= '0;
            m0_resp  <= 1'b0;
            m1_rdata <= '0;
            m1_resp  <= 1'b0;
`ifdef CACHE_ARB_WATCHDOG_EN
            wd_q     <= '0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            m0_resp <= 1'b0;
            m1_resp <= 1'b0;
`ifdef CACHE_ARB_WATCHDOG_EN
            m0_err  <= 1'b0;
            m1_err  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= gnt1;
                        c_cmd   <= win_cmd;
                        c_addr  <= win_addr;
                        c_wdata <= win_wdata;
                        beats_q <= (win_cmd == CMD_READ32) ? 2'd2 : 2'd1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    c_cmd   <= '0;
`ifdef CACHE_ARB_WATCHDOG_EN
                    wd_q    <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (c_resp) begin
                        if (owner_q) begin
                            m1_rdata <= c_rdata;
                            m1_resp  <= 1'b1;
                        end else begin
                            m0_rdata <= c_rdata;
                            m0_resp  <= 1'b1;
                        end
                        beats_q <= beats_q - 2'd1;
`ifdef CACHE_ARB_WATCHDOG_EN
                        wd_q    <= '0;
`endif
                        if (beats_q == 2'd1) begin
                            last_q  <= owner_q;
                            state_q <= S_DONE;
                        end
                    end
`ifdef CACHE_ARB_WATCHDOG_EN
                    else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        m0_err  <= !owner_q;
                        m1_err  <= owner_q;
                        last_q  <= owner_q;
                        state_q <= S_DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                // Gives the owner a cycle to drop its command before re-arbitration.
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-master arbiter that shares the cache's single CPU-side port between two requesters (e.g. two CPU cores or a CPU and a DMA/test driver). It registers each winning master's command, address and write data, issues the command to the cache for exactly one cycle and counts response beats. It routes each beat back to the owner and then releases the port using round-robin priority. It sits between the requesters and the cache, with unidirectional split buses in place of the shared tri-state bus.

## Interface
- ADDR_W, 14, address width (cache line tag+set+offset)
- DATA_W, 16, data beat width
- TIMEOUT, 255, max wait cycles for a cache response (used only with the watchdog enabled)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_cmd  in  3  master 0 command: 0 NOP, 1 READ8, 2 READ16, 3 READ32, 4 INVALIDATE, 5 WRITE8, 6 WRITE16, 7 WRITE32
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  read beat to master 0
- m0_resp  out  1  response beat strobe to master 0
- m0_err  out  1  timeout abort strobe to master 0
- m1_cmd, m1_addr, m1_wdata, m1_rdata, m1_resp, m1_err  same as master 0
- c_cmd  out  3  command to cache
- c_addr  out  ADDR_W  address to cache
- c_wdata  out  DATA_W  write data to cache
- c_rdata  in  DATA_W  read beat from cache
- c_resp  in  1  cache response beat valid

## Operation
- All outputs registered. Reset values: every output 0, state IDLE, last-grant pointer = 1, so master 0 wins first.
- A request is any nonzero mN_cmd. A master holds cmd/addr/wdata stable until it sees its final resp or err.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if exactly one master requests, grant it. If both request, grant the master opposite the last-grant pointer. Latch the winner's cmd, addr and wdata. Set the beat count: 2 for READ32, 1 for all other commands.
- ISSUE (1 cycle): c_cmd = latched cmd, c_addr and c_wdata = latched values.
- WAIT: c_cmd = 0; c_addr and c_wdata stay held. On each c_resp cycle:
  - register c_rdata to the owner's mN_rdata;
  - pulse mN_resp the next cycle;
  - decrement the beat count.
- On the last beat, go to DONE and update the last-grant pointer to the owner.
- DONE (1 cycle): no new grant. This gives the owner one cycle to deassert cmd, so a stale request is never re-sampled.
- Non-owner outputs (rdata/resp/err) stay 0 throughout.
- c_resp while in IDLE, ISSUE or DONE is ignored and is not forwarded.
- Asserting reset_n low mid-transaction returns to IDLE immediately. All outputs clear, and the pointer resets to 1.

## Timing
- Request seen in IDLE at cycle T -> c_cmd valid during T+1 -> WAIT from T+2.
- Cache beat at cycle R -> mN_resp/mN_rdata valid at R+1.
- Final beat at R -> DONE at R+1 -> IDLE at R+2; the next grant is sampled at the end of R+2.
- Back-to-back minimum occupancy per single-beat transaction: 4 cycles (cache answering at T+2).
- Arbitration latency from request to c_cmd: 1 cycle when the port is idle.

## Configuration
- CACHE_ARB_WATCHDOG_EN defined:
  - a counter runs in WAIT and reloads on each c_resp;
  - when it reaches TIMEOUT with beats still outstanding, pulse mN_err to the owner for 1 cycle, go to DONE and advance the pointer;
  - late cache beats that arrive afterwards are ignored.
- Not defined: no counter; m0_err/m1_err tied 0; WAIT lasts until all beats arrive.

## Test plan
- Reset: hold reset_n=0 with m0_cmd=2 -> all outputs 0. Release -> c_cmd=2 one cycle after the first sampling edge, with c_addr=m0_addr.
- Single READ16 from m1 at addr 0x1234: cache returns c_rdata=0xBEEF two cycles after issue -> m1_resp=1, m1_rdata=0xBEEF one cycle later; m0_resp stays 0.
- READ32 from m0, cache beats 0x1111 then 0x2222 -> two m0_resp pulses carrying those values in order; c_cmd=3 for exactly one cycle.
- Both masters request continuously with WRITE16 -> grants alternate m0, m1, m0, m1; no master is granted twice in a row.
- Reset pulse during WAIT -> outputs clear asynchronously; the next request is granted to m0.
- With CACHE_ARB_WATCHDOG_EN, TIMEOUT=8, cache silent -> m0_err pulses 8 cycles after entering WAIT; a late c_resp is not forwarded; m1's pending request is granted next.
